// File: rtl/countdown_display_driver.sv
// countdown_display_driver: remaining-seconds countdown shown on a 2-digit multiplexed 7-segment display
module countdown_display_driver #(
    parameter int DUR_GREEN   = 30,
    parameter int DUR_YELLOW  = 3,
    parameter int DUR_PED     = 15,
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] phase,
    input  logic [4:0] count,
    input  logic       sample,
    output logic [6:0] seg_n,
    output logic [1:0] an_n,
    output logic       busy
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t state, state_nx;

    logic [5:0]    dur, rem_in, work, pend_rem;
    logic [3:0]    tens_w, tens, ones, digit;
    logic [2:0]    ph_w, pend_ph, disp_ph;
    logic          pend_v, sel, blink_on, blank;
    logic [RW-1:0] ref_cnt;
    logic [BW-1:0] blink_cnt;
    logic [6:0]    seg_nx;
    logic [1:0]    an_nx;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0: enc = 7'h01;
            4'd1: enc = 7'h4F;
            4'd2: enc = 7'h12;
            4'd3: enc = 7'h06;
            4'd4: enc = 7'h4C;
            4'd5: enc = 7'h24;
            4'd6: enc = 7'h20;
            4'd7: enc = 7'h0F;
            4'd8: enc = 7'h00;
            4'd9: enc = 7'h04;
            default: enc = 7'h7F;
        endcase
    endfunction

    // invalid phases get dur = 0, so rem saturates to 0 for them
    always_comb begin
        dur = (phase == 3'd0 || phase == 3'd2) ? 6'(DUR_GREEN) :
              (phase == 3'd1 || phase == 3'd3 || phase == 3'd5) ? 6'(DUR_YELLOW) :
              (phase == 3'd4) ? 6'(DUR_PED) : 6'd0;
        rem_in = ({1'b0, count} > dur) ? 6'd0 : dur - {1'b0, count};
    end

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (sample || pend_v) ? CONV : IDLE;
            CONV:    state_nx = (work < 6'd10) ? DONE : CONV;
            DONE:    state_nx = pend_v ? CONV : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work     <= '0;
            tens_w   <= '0;
            ph_w     <= 3'b111;
            pend_v   <= 1'b0;
            pend_ph  <= '0;
            pend_rem <= '0;
            disp_ph  <= 3'b111;
            tens     <= '0;
            ones     <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample) begin
                        ph_w   <= phase;
                        work   <= rem_in;
                        tens_w <= '0;
                        busy   <= 1'b1;
                        pend_v <= 1'b0;
                    end else if (pend_v) begin
                        ph_w   <= pend_ph;
                        work   <= pend_rem;
                        tens_w <= '0;
                        busy   <= 1'b1;
                        pend_v <= 1'b0;
                    end
                end
                CONV: begin
                    if (work >= 6'd10) begin
                        work   <= work - 6'd10;
                        tens_w <= tens_w + 4'd1;
                    end
                    if (sample) begin
                        pend_v   <= 1'b1;
                        pend_ph  <= phase;
                        pend_rem <= rem_in;
                    end
                end
                DONE: begin
                    tens    <= tens_w;
                    ones    <= work[3:0];
                    disp_ph <= ph_w;
                    if (pend_v) begin
                        ph_w   <= pend_ph;
                        work   <= pend_rem;
                        tens_w <= '0;
                    end else
                        busy <= 1'b0;
                    // a sample on this edge becomes the new pending one, after any old one is consumed
                    pend_v <= sample;
                    if (sample) begin
                        pend_ph  <= phase;
                        pend_rem <= rem_in;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt   <= '0;
            sel       <= 1'b0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            ref_cnt   <= (ref_cnt == RW'(REFRESH_DIV - 1)) ? '0 : ref_cnt + 1'b1;
            sel       <= (ref_cnt == RW'(REFRESH_DIV - 1)) ? ~sel : sel;
            blink_cnt <= (blink_cnt == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt + 1'b1;
            blink_on  <= (blink_cnt == BW'(BLINK_DIV - 1)) ? ~blink_on : blink_on;
        end
    end

    always_comb begin
        digit  = sel ? tens : ones;
        blank  = (disp_ph > 3'd5) || (disp_ph[0] && !blink_on) || (sel && tens == 4'd0);
        seg_nx = blank ? 7'h7F : enc(digit);
        an_nx  = blank ? 2'b11 : (sel ? 2'b01 : 2'b10);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_n <= 7'h7F;
            an_n  <= 2'b11;
        end else begin
            seg_n <= seg_nx;
            an_n  <= an_nx;
        end
    end
endmodule

// File: tb/tb_countdown_display_driver.sv
// tb_countdown_display_driver: directed stimulus checked against a time-based display model
module tb_countdown_display_driver;
    logic       clk = 0, rst = 1, sample = 0;
    logic [2:0] phase = 0;
    logic [4:0] count = 0;
    logic [6:0] seg_n;
    logic [1:0] an_n;
    logic       busy;
    int checks = 0, errors = 0;

    countdown_display_driver #(.REFRESH_DIV(4), .BLINK_DIV(8)) dut (
        .clk(clk), .rst(rst), .phase(phase), .count(count), .sample(sample),
        .seg_n(seg_n), .an_n(an_n), .busy(busy)
    );

    always #5 clk = ~clk;

    int seg_tab [10] = '{'h01, 'h4F, 'h12, 'h06, 'h4C, 'h24, 'h20, 'h0F, 'h00, 'h04};

    // model: display content, conversion finish time and a one-deep pending sample
    int cyc = 0, mj = 0, m_ph = 7, m_t = 0, m_o = 0;
    int m_act = 0, m_done = 0, m_cph = 0, m_rt = 0, m_ro = 0;
    int p_v = 0, p_ph = 0, p_rem = 0, m_busy = 0, e_seg = 'h7F, e_an = 3, mv = 0;

    function automatic int rem_of(int ph, int c);
        int d;
        d = (ph == 0 || ph == 2) ? 30 : (ph == 1 || ph == 3 || ph == 5) ? 3 : (ph == 4) ? 15 : 0;
        return (c > d) ? 0 : d - c;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic start(input int ph, input int rem);
        m_cph = ph; m_rt = rem / 10; m_ro = rem % 10;
        m_done = cyc + rem / 10 + 2; m_act = 1;
    endtask

    task automatic step();
        int s, bo;
        cyc++;
        if (rst) begin
            mj = 0; m_ph = 7; m_t = 0; m_o = 0; m_act = 0; p_v = 0;
            e_seg = 'h7F; e_an = 3; mv = 1;
        end else begin
            s = (mj / 4) % 2;
            bo = ((mj / 8) % 2) == 0;
            if (m_ph > 5 || (m_ph % 2 == 1 && !bo) || (s == 1 && m_t == 0)) begin
                e_seg = 'h7F; e_an = 3;
            end else begin
                e_seg = seg_tab[s ? m_t : m_o]; e_an = s ? 1 : 2;
            end
            mj++;
            if (m_act && cyc == m_done) begin
                m_ph = m_cph; m_t = m_rt; m_o = m_ro;
                if (p_v) begin start(p_ph, p_rem); p_v = 0; end
                else m_act = 0;
                if (sample) begin p_v = 1; p_ph = phase; p_rem = rem_of(phase, count); end
            end else if (m_act) begin
                if (sample) begin p_v = 1; p_ph = phase; p_rem = rem_of(phase, count); end
            end else if (sample) begin
                start(phase, rem_of(phase, count)); p_v = 0;
            end else if (p_v) begin
                start(p_ph, p_rem); p_v = 0;
            end
        end
        m_busy = m_act;
    endtask

    initial forever begin
        @(posedge clk);
        step();
        @(negedge clk);
        if (mv) begin
            chk("seg_n", seg_n, e_seg);
            chk("an_n", an_n, e_an);
            chk("busy", busy, m_busy);
        end
    end

    task automatic pulse(input int ph, input int c);
        phase = 3'(ph); count = 5'(c); sample = 1;
        @(negedge clk);
    endtask

    task automatic wait_an(input int v);
        int i;
        for (i = 0; i < 40 && an_n != 2'(v); i++) @(negedge clk);
        chk("wait_an", an_n, v);
    endtask

    task automatic idle(input int n);
        sample = 0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int nb, n10, good, nz;
        repeat (3) @(negedge clk);
        chk("rst_seg", seg_n, 'h7F);
        chk("rst_an", an_n, 3);
        chk("rst_busy", busy, 0);
        rst = 0;
        idle(10);
        chk("idle_blank", an_n, 3);

        pulse(0, 0); sample = 0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin nb += busy; @(negedge clk); end
        chk("green_busy_len", nb, 5);
        wait_an(2); chk("green_ones", seg_n, 'h01);
        wait_an(1); chk("green_tens", seg_n, 'h06);

        pulse(2, 23); idle(4);
        wait_an(2); chk("lz_ones", seg_n, 'h0F);
        nz = 0;
        for (int i = 0; i < 16; i++) begin nz += (an_n != 2 && an_n != 3); @(negedge clk); end
        chk("lz_tens_blank", nz, 0);

        pulse(1, 0); idle(6);
        n10 = 0; good = 0;
        for (int i = 0; i < 32; i++) begin
            if (an_n == 2) begin n10++; good += (seg_n == 7'h06); end
            @(negedge clk);
        end
        chk("yel_on_cycles", n10, 8);
        chk("yel_digit3", good, 8);

        pulse(3, 5); idle(6);
        n10 = 0; good = 0;
        for (int i = 0; i < 32; i++) begin
            if (an_n == 2) begin n10++; good += (seg_n == 7'h01); end
            @(negedge clk);
        end
        chk("sat_on_cycles", n10, 8);
        chk("sat_digit0", good, 8);

        pulse(0, 0); pulse(4, 2); pulse(4, 9); sample = 0;
        nz = 0;
        for (int i = 0; i < 5; i++) begin nz += !busy; @(negedge clk); end
        chk("chain_busy_gap", nz, 0);
        idle(4);
        chk("chain_done", busy, 0);
        wait_an(2); chk("chain_ones6", seg_n, 'h20);

        pulse(6, 0); idle(6);
        nz = 0;
        for (int i = 0; i < 16; i++) begin nz += (an_n != 3); @(negedge clk); end
        chk("invalid_blank", nz, 0);

        pulse(0, 0); sample = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_busy", busy, 0);
        chk("midrst_seg", seg_n, 'h7F);
        nz = 0;
        for (int i = 0; i < 20; i++) begin nz += (an_n != 3) + busy; @(negedge clk); end
        chk("midrst_no_stale", nz, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
